// File: rtl/mos6502_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mos6502_pkg
// Description : Shared ALU opcode encodings and status-register bit indices.
// Revision    : 1.0  initial release
// ============================================================================
package mos6502_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_EOR  = 4'h4;
    localparam logic [3:0] ALU_ASL  = 4'h5;
    localparam logic [3:0] ALU_LSR  = 4'h6;
    localparam logic [3:0] ALU_ROL  = 4'h7;
    localparam logic [3:0] ALU_ROR  = 4'h8;
    localparam logic [3:0] ALU_INC  = 4'h9;
    localparam logic [3:0] ALU_DEC  = 4'hA;
    localparam logic [3:0] ALU_PASS = 4'hB;

    // Bit positions inside the processor status register (NV-BDIZC)
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_I = 2;
    localparam int unsigned FLAG_D = 3;
    localparam int unsigned FLAG_B = 4;
    localparam int unsigned FLAG_V = 6;
    localparam int unsigned FLAG_N = 7;

endpackage : mos6502_pkg
`default_nettype wire

// File: rtl/mos6502_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : mos6502_alu_if
// Description : Operand/result bus between the operand muxes and the ALU.
// Revision    : 1.0  initial release
// ============================================================================
interface mos6502_alu_if;

    logic [3:0] alu_control;
    logic [7:0] alu_AI;
    logic [7:0] alu_BI;
    logic       alu_carry_in;
    logic [7:0] alu_Y;
    logic       alu_carry_out;
    logic       alu_overflow;
    logic       alu_negative;
    logic       alu_zero;

    modport master (
        output alu_control,
        output alu_AI,
        output alu_BI,
        output alu_carry_in,
        input  alu_Y,
        input  alu_carry_out,
        input  alu_overflow,
        input  alu_negative,
        input  alu_zero
    );

    modport slave (
        input  alu_control,
        input  alu_AI,
        input  alu_BI,
        input  alu_carry_in,
        output alu_Y,
        output alu_carry_out,
        output alu_overflow,
        output alu_negative,
        output alu_zero
    );

endinterface : mos6502_alu_if
`default_nettype wire

// File: rtl/mos6502_alu_core.sv
`default_nettype none
// ============================================================================
// Module      : mos6502_alu_core
// Description : Combinational opcode decode and 9-bit adder; next Y/C/V.
// Revision    : 1.0  initial release
// ============================================================================
module mos6502_alu_core
    import mos6502_pkg::*;
(
    input  logic [3:0] alu_control,
    input  logic [7:0] alu_AI,
    input  logic [7:0] alu_BI,
    input  logic       alu_carry_in,
    output logic [7:0] y_d,
    output logic       c_d,
    output logic       v_d
);

    logic [7:0] b_eff;
    logic [8:0] sum;

    // SUB reuses the adder with inverted B; carry-in acts as not-borrow
    always_comb begin
        b_eff = (alu_control == ALU_SUB) ? ~alu_BI : alu_BI;
        sum   = {1'b0, alu_AI} + {1'b0, b_eff} + {8'h00, alu_carry_in};
    end

    always_comb begin
        y_d = 8'h00;
        c_d = 1'b0;
        v_d = 1'b0;
        case (alu_control)
            ALU_ADD, ALU_SUB: begin
                y_d = sum[7:0];
                c_d = sum[8];
                v_d = (alu_AI[7] == b_eff[7]) && (sum[7] != alu_AI[7]);
            end
            ALU_AND:  y_d = alu_AI & alu_BI;
            ALU_OR:   y_d = alu_AI | alu_BI;
            ALU_EOR:  y_d = alu_AI ^ alu_BI;
            ALU_ASL: begin
                y_d = {alu_AI[6:0], 1'b0};
                c_d = alu_AI[7];
            end
            ALU_LSR: begin
                y_d = {1'b0, alu_AI[7:1]};
                c_d = alu_AI[0];
            end
            ALU_ROL: begin
                y_d = {alu_AI[6:0], alu_carry_in};
                c_d = alu_AI[7];
            end
            ALU_ROR: begin
                y_d = {alu_carry_in, alu_AI[7:1]};
                c_d = alu_AI[0];
            end
            ALU_INC:  y_d = alu_AI + 8'h01;
            ALU_DEC:  y_d = alu_AI - 8'h01;
            ALU_PASS: y_d = alu_AI;
            default: begin
                y_d = 8'h00;
                c_d = 1'b0;
                v_d = 1'b0;
            end
        endcase
    end

endmodule : mos6502_alu_core
`default_nettype wire

// File: rtl/mos6502_alu.sv
`default_nettype none
// ============================================================================
// Module      : mos6502_alu
// Description : Registered 6502 ALU; one-cycle latency, N/Z from registered Y.
// Revision    : 1.0  initial release
// ============================================================================
module mos6502_alu
    import mos6502_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    mos6502_alu_if.slave  alu_bus
);

    logic [7:0] y_d;
    logic [7:0] y_q;
    logic       c_d;
    logic       c_q;
    logic       v_d;
    logic       v_q;

    mos6502_alu_core u_core (
        .alu_control  (alu_bus.alu_control),
        .alu_AI       (alu_bus.alu_AI),
        .alu_BI       (alu_bus.alu_BI),
        .alu_carry_in (alu_bus.alu_carry_in),
        .y_d          (y_d),
        .c_d          (c_d),
        .v_d          (v_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q <= 8'h00;
            c_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            y_q <= y_d;
            c_q <= c_d;
            v_q <= v_d;
        end
    end

    assign alu_bus.alu_Y         = y_q;
    assign alu_bus.alu_carry_out = c_q;
    assign alu_bus.alu_overflow  = v_q;
    assign alu_bus.alu_negative  = y_q[7];
    assign alu_bus.alu_zero      = (y_q == 8'h00);

endmodule : mos6502_alu
`default_nettype wire

// File: tb/tb_mos6502_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mos6502_alu
// Description : Self-checking bench: directed table, exhaustive ADD, random ops.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mos6502_alu;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    mos6502_alu_if bus ();

    mos6502_alu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .alu_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] y;
        logic       c;
        logic       v;
        logic       n;
        logic       z;
    } vec_t;

    vec_t vecs[$];

    // Reference model from the arithmetic definition of each opcode
    task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, output logic [7:0] y, output logic c, output logic v,
                         output logic n, output logic z);
        int ua, ub, sa, sb, s, sr;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        s  = 0;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            4'h0: begin
                s  = ua + ub + int'(cin);
                sr = sa + sb + int'(cin);
                c  = (s > 255);
                v  = (sr > 127) || (sr < -128);
            end
            4'h1: begin
                s  = ua + (255 - ub) + int'(cin);
                sr = sa - sb - 1 + int'(cin);
                c  = (s > 255);
                v  = (sr > 127) || (sr < -128);
            end
            4'h2: s = int'(a & b);
            4'h3: s = int'(a | b);
            4'h4: s = int'(a ^ b);
            4'h5: begin s = ua * 2; c = (ua >= 128); end
            4'h6: begin s = ua / 2; c = (ua % 2) == 1; end
            4'h7: begin s = ua * 2 + int'(cin); c = (ua >= 128); end
            4'h8: begin s = ua / 2 + 128 * int'(cin); c = (ua % 2) == 1; end
            4'h9: s = ua + 1;
            4'hA: s = ua + 255;
            4'hB: s = ua;
            default: s = 0;
        endcase
        y = 8'(s % 256);
        n = ((s % 256) >= 128);
        z = ((s % 256) == 0);
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic cin);
        bus.alu_control  = op;
        bus.alu_AI       = a;
        bus.alu_BI       = b;
        bus.alu_carry_in = cin;
    endtask

    task automatic compare(input string name, input logic [7:0] ey, input logic ec,
                           input logic ev, input logic en, input logic ez);
        n_checks++;
        if (bus.alu_Y !== ey || bus.alu_carry_out !== ec || bus.alu_overflow !== ev ||
            bus.alu_negative !== en || bus.alu_zero !== ez) begin
            n_errors++;
            $display("FAIL %s: got Y=%02h C=%b V=%b N=%b Z=%b, want Y=%02h C=%b V=%b N=%b Z=%b",
                     name, bus.alu_Y, bus.alu_carry_out, bus.alu_overflow, bus.alu_negative,
                     bus.alu_zero, ey, ec, ev, en, ez);
        end
    endtask

    // Apply one operation, clock it through, compare against the model
    task automatic run_model(input string name, input logic [3:0] op, input logic [7:0] a,
                             input logic [7:0] b, input logic cin);
        logic [7:0] ey;
        logic ec, ev, en, ez;
        model(op, a, b, cin, ey, ec, ev, en, ez);
        drive(op, a, b, cin);
        @(posedge clk);
        #1;
        compare(name, ey, ec, ev, en, ez);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        vecs.push_back('{"add_50_50",  4'h0, 8'h50, 8'h50, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{"add_ff_01",  4'h0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"add_80_80",  4'h0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"sub_50_b0",  4'h1, 8'h50, 8'hB0, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{"sub_05_03",  4'h1, 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sub_borrow", 4'h1, 8'h05, 8'h03, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"asl_81",     4'h5, 8'h81, 8'h00, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"lsr_81",     4'h6, 8'h81, 8'h00, 1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"rol_81",     4'h7, 8'h81, 8'h00, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"ror_81",     4'h8, 8'h81, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"ror_cin",    4'h8, 8'h02, 8'h00, 1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"and_f0_3c",  4'h2, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"or_f0_3c",   4'h3, 8'hF0, 8'h3C, 1'b1, 8'hFC, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"eor_f0_3c",  4'h4, 8'hF0, 8'h3C, 1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"inc_ff",     4'h9, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"dec_00",     4'hA, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"pass_7f",    4'hB, 8'h7F, 8'hFF, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"rsv_c",      4'hC, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"rsv_f",      4'hF, 8'h81, 8'h7E, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});

        drive(4'h0, 8'h12, 8'h34, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare("reset_state", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
            @(posedge clk);
            #1;
            compare(vecs[i].name, vecs[i].y, vecs[i].c, vecs[i].v, vecs[i].n, vecs[i].z);
        end

        // Every ADD operand pair; carry-in randomised per pair
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                run_model("add_exh", 4'h0, 8'(a), 8'(b), 1'($urandom_range(0, 1)));
            end
        end

        for (int i = 0; i < 3000; i++) begin
            run_model("random", 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                      1'($urandom_range(0, 1)));
        end

        // Reset mid-stream: the result computed in the reset cycle is dropped
        for (int i = 0; i < 4; i++) begin
            run_model("pre_reset_add", 4'h0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        drive(4'h0, 8'hFF, 8'hFF, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        compare("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        run_model("post_reset_first", 4'h0, 8'h50, 8'h50, 1'b0);
        run_model("post_reset_second", 4'h1, 8'h00, 8'h01, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mos6502_alu
`default_nettype wire
